// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory port and IF/ID outputs.
// The fetch stage uses the master modport; the environment (hazard unit, memory, decode) uses slave.
interface fetch_stage_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic [31:0]      imem_instruction;
  logic [31:0]      imem_pc;
  logic [31:0]      ifid_instruction;
  logic [31:0]      ifid_pc_plus4;
  logic             ifid_valid;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_instruction,
    output imem_pc, ifid_instruction, ifid_pc_plus4, ifid_valid, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_instruction,
    input  imem_pc, ifid_instruction, ifid_pc_plus4, ifid_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives it to the combinational instruction
// memory and latches the returned word into the IF/ID register for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  logic [31:0]      r_pc;
  logic [31:0]      r_ifid_instruction;
  logic [31:0]      r_ifid_pc_plus4;
  logic             r_ifid_valid;
  logic [CNT_W-1:0] r_fetch_count;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_branch_pc;
  logic [31:0]      w_pc_nxt;
  logic [31:0]      w_instr_nxt;
  logic [31:0]      w_pc_plus4_nxt;
  logic             w_valid_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  // Per-edge control: branch_taken redirects and squashes even when stall is high
  // (a wrong-path IF/ID entry must never survive); otherwise stall freezes all
  // state; otherwise the word at the current PC is accepted into IF/ID.
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_branch_pc = {bus.branch_target[31:2], 2'b00};

  always_comb begin
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_ifid_instruction;
    w_pc_plus4_nxt = r_ifid_pc_plus4;
    w_valid_nxt    = r_ifid_valid;
    w_count_nxt    = r_fetch_count;
    if (bus.branch_taken) begin
      w_pc_nxt       = w_branch_pc;
      w_instr_nxt    = 32'h0000_0000;
      w_pc_plus4_nxt = 32'h0000_0000;
      w_valid_nxt    = 1'b0;
    end else if (!bus.stall) begin
      w_pc_nxt       = w_pc_plus4;
      w_instr_nxt    = bus.imem_instruction;
      w_pc_plus4_nxt = w_pc_plus4;
      w_valid_nxt    = 1'b1;
      w_count_nxt    = r_fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc               <= RESET_PC;
      r_ifid_instruction <= 32'h0000_0000;
      r_ifid_pc_plus4    <= 32'h0000_0000;
      r_ifid_valid       <= 1'b0;
      r_fetch_count      <= '0;
    end else begin
      r_pc               <= w_pc_nxt;
      r_ifid_instruction <= w_instr_nxt;
      r_ifid_pc_plus4    <= w_pc_plus4_nxt;
      r_ifid_valid       <= w_valid_nxt;
      r_fetch_count      <= w_count_nxt;
    end
  end

  assign bus.imem_pc          = r_pc;
  assign bus.ifid_instruction = r_ifid_instruction;
  assign bus.ifid_pc_plus4    = r_ifid_pc_plus4;
  assign bus.ifid_valid       = r_ifid_valid;
  assign bus.fetch_count      = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table of per-edge stimulus and expected
// state, then hand-written async-reset and 4-bit counter-wrap sequences.
module tb_fetch_stage;

  logic clk;
  logic rst;
  logic rst_w;

  int checks;
  int failures;

  fetch_stage_if #(.CNT_W(32)) bus ();
  fetch_stage_if #(.CNT_W(4))  bus_w ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut_w (
    .clk (clk),
    .rst (rst_w),
    .bus (bus_w.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Instruction memory: word k holds 0x1000_0000 + k.
  always_comb bus.imem_instruction   = 32'h1000_0000 + (bus.imem_pc >> 2);
  always_comb bus_w.imem_instruction = 32'h1000_0000 + (bus_w.imem_pc >> 2);

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] target;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pp4;
    logic        exp_valid;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pp4, input logic valid, input logic [31:0] cnt);
    check({tag, ".imem_pc"}, bus.imem_pc, pc);
    check({tag, ".ifid_instruction"}, bus.ifid_instruction, instr);
    check({tag, ".ifid_pc_plus4"}, bus.ifid_pc_plus4, pp4);
    check({tag, ".ifid_valid"}, {31'd0, bus.ifid_valid}, {31'd0, valid});
    check({tag, ".fetch_count"}, bus.fetch_count, cnt);
  endtask

  task automatic drive(input logic stall, input logic br, input logic [31:0] target);
    bus.stall         = stall;
    bus.branch_taken  = br;
    bus.branch_target = target;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    rst_w    = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    bus_w.stall         = 1'b0;
    bus_w.branch_taken  = 1'b0;
    bus_w.branch_target = 32'h0;

    //               stall br  target        pc            instr         pp4           v     cnt
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,       1'b1, 32'd1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,       1'b1, 32'd2});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,       1'b1, 32'd2});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,       1'b1, 32'd2});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,       1'b1, 32'd2});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'hC,        32'h1000_0002, 32'hC,       1'b1, 32'd3});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h10,       32'h1000_0003, 32'h10,      1'b1, 32'd4});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h14,       32'h1000_0004, 32'h14,      1'b1, 32'd5});
    vecs.push_back('{1'b1, 1'b1, 32'h40,       32'h40,       32'h0,         32'h0,       1'b0, 32'd5});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h44,       32'h1000_0010, 32'h44,      1'b1, 32'd6});
    vecs.push_back('{1'b0, 1'b1, 32'h23,       32'h20,       32'h0,         32'h0,       1'b0, 32'd6});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h24,       32'h1000_0008, 32'h24,      1'b1, 32'd7});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,       32'h0,       1'b0, 32'd7});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        32'h4FFF_FFFF, 32'h0,       1'b1, 32'd8});
    vecs.push_back('{1'b0, 1'b1, 32'h0,        32'h0,        32'h0,         32'h0,       1'b0, 32'd8});
    vecs.push_back('{1'b0, 1'b1, 32'h0,        32'h0,        32'h0,         32'h0,       1'b0, 32'd8});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,       1'b1, 32'd9});

    // Reset state, held across an edge.
    #12;
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    step();
    check_state("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].target);
      step();
      check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_instr,
                  vecs[i].exp_pp4, vecs[i].exp_valid, vecs[i].exp_cnt);
    end

    // Ten more fetches, then asynchronous reset between edges.
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) step();
    check_state("pre_async", 32'h2C, 32'h1000_000A, 32'h2C, 1'b1, 32'd19);
    #3;
    rst = 1'b0;
    #1;
    check_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    #3;
    rst = 1'b1;
    step();
    check_state("resume", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd1);

    // 4-bit counter wraps after 16 fetches.
    step();
    rst_w = 1'b1;
    for (int i = 0; i < 17; i++) step();
    check("wrap.fetch_count", {28'd0, bus_w.fetch_count}, 32'd1);
    check("wrap.imem_pc", bus_w.imem_pc, 32'd68);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
